fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, the first fetch address after reset.
REQ-002 SHALL have port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, the reset; synchronous and active-low.
REQ-004 SHALL have port pcWrite, input, 1, from hazard detection: 1 = pipeline may advance, 0 = hold PC and IF/ID.
REQ-005 SHALL have port flush, input, 1, 1 = load a bubble into IF/ID at the next edge.
REQ-006 SHALL have port pcSrc, input, 1, 1 = redirect fetch to redirectTarget.
REQ-007 SHALL have port redirectTarget, input, 32, the branch or jump target address.
REQ-008 SHALL have port imemReq, output, 1, the instruction memory request.
REQ-009 SHALL have port imemAddr, output, 32, the instruction memory address.
REQ-010 SHALL have port imemReady, input, 1, imemData is valid this cycle for the outstanding request.
REQ-011 SHALL have port imemData, input, 32, the fetched instruction word.
REQ-012 SHALL have port pcIF, output, 32, the current fetch PC.
REQ-013 SHALL have port pcID, output, 32, the IF/ID register's PC+4.
REQ-014 SHALL have port instructionID, output, 32, the IF/ID register's instruction.
REQ-015 SHALL have port validID, output, 1, IF/ID holds a real instruction.

Function
REQ-016 SHALL implement a 4-state FSM: BOOT, FETCH, HELD, DISCARD; BOOT always goes to FETCH after one cycle.
REQ-017 SHALL define a bubble as pcID=0, instructionID=32'h00000000 (NOP), validID=0.
REQ-018 SHALL drive imemReq as follows: 0 in BOOT and HELD; 1 in FETCH and DISCARD.
REQ-019 SHALL drive imemAddr=pcIF in FETCH; in DISCARD it SHALL drive the latched abandoned address, unchanged until imemReady.
REQ-020 SHALL ignore pcSrc whenever pcWrite=0 (no redirect is accepted while stalled).
REQ-021 SHALL, in FETCH with imemReady=1, pcWrite=1, pcSrc=0: set IF/ID to {pcIF+4, imemData, 1} and pcIF to pcIF+4, and stay in FETCH (one instruction per cycle with zero-wait memory).
REQ-022 SHALL, in FETCH with imemReady=1, pcWrite=1, pcSrc=1: drop imemData, load a bubble into IF/ID, set pcIF to redirectTarget, and stay in FETCH.
REQ-023 SHALL, in FETCH with imemReady=0, pcWrite=1, pcSrc=1: latch imemAddr, set pcIF to redirectTarget, load a bubble into IF/ID, and go to DISCARD.
REQ-024 SHALL, in FETCH with imemReady=0 and no redirect: hold pcIF, load a bubble into IF/ID if pcWrite=1, and hold IF/ID if pcWrite=0.
REQ-025 SHALL, in FETCH with imemReady=1, pcWrite=0: capture imemData into a one-entry buffer, hold pcIF and IF/ID, and go to HELD.
REQ-026 SHALL, in HELD: while pcWrite=0, hold everything.
REQ-027 SHALL, in HELD with pcWrite=1, pcSrc=0: set IF/ID to {pcIF+4, buffer, 1}, set pcIF to pcIF+4, and go to FETCH.
REQ-028 SHALL, in HELD with pcWrite=1, pcSrc=1: drop the buffer, load a bubble into IF/ID, set pcIF to redirectTarget, and go to FETCH.
REQ-029 SHALL, in DISCARD: load a bubble into IF/ID if pcWrite=1, and hold IF/ID if pcWrite=0.
REQ-030 SHALL, in DISCARD with imemReady=1: drop the data and go to FETCH.
REQ-031 SHALL, in DISCARD with pcWrite=1 and pcSrc=1: update pcIF to the new redirectTarget and remain in DISCARD.
REQ-032 SHALL give flush=1 priority over every IF/ID rule above, loading a bubble regardless of pcWrite; PC and FSM behaviour SHALL be unaffected by flush.
REQ-033 SHALL compute pcIF+4 modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.
REQ-034 SHALL keep pcIF constant whenever pcWrite=0.

Reset
REQ-035 SHALL, on Reset=0 at a rising edge, set state=BOOT, pcIF=RESET_PC, IF/ID=bubble, and the buffer invalid; imemReq SHALL be 0 in the cycle that follows.
REQ-036 SHALL, on reset mid-request (FETCH or DISCARD), abandon the request; any later imemReady for it SHALL be ignored because imemReq=0 in BOOT.

Verification
REQ-037 SHALL cover: reset, then imemReady=1 every cycle with pcWrite=1 and imem returning the address as data -> imemAddr 0,4,8; after three accepted fetches pcID=12, instructionID=8, validID=1.
REQ-038 SHALL cover: imemReady=1 with pcWrite=0 for 3 cycles -> imemReq=0 and IF/ID unchanged while held; when pcWrite=1, the buffered word appears in instructionID with no new request.
REQ-039 SHALL cover: pcSrc=1 with redirectTarget=32'h40 while a request to 0x10 is waiting -> imemAddr stays 0x10 until imemReady, its data is dropped, and the next request is to 0x40.
REQ-040 SHALL cover: flush=1 with pcWrite=0 -> validID=0 and instructionID=0 next cycle, with pcIF unchanged.
REQ-041 SHALL cover: RESET_PC=32'hFFFFFFFC, one accepted fetch -> pcIF=0 and pcID=0.
REQ-042 SHALL cover: Reset=0 during DISCARD -> next cycle pcIF=RESET_PC, imemReq=0, validID=0.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC register, imem request FSM, IF/ID register
// Stall-held word goes to a one-entry buffer; redirects during an outstanding request wait out the abandoned response.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        pcWrite,
    input  logic        flush,
    input  logic        pcSrc,
    input  logic [31:0] redirectTarget,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic [31:0] pcIF,
    output logic [31:0] pcID,
    output logic [31:0] instructionID,
    output logic        validID
);

    typedef enum logic [1:0] {BOOT, FETCH, HELD, DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_ins_q, id_ins_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] lost_addr_q, lost_addr_d;
    logic [31:0] pc_plus4;
    logic        bubble;

    assign pc_plus4      = pc_q + 32'd4;
    assign imemReq       = (state_q == FETCH) || (state_q == DISCARD);
    assign imemAddr      = (state_q == DISCARD) ? lost_addr_q : pc_q;
    assign pcIF          = pc_q;
    assign pcID          = id_pc_q;
    assign instructionID = id_ins_q;
    assign validID       = id_valid_q;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        id_pc_d     = id_pc_q;
        id_ins_d    = id_ins_q;
        id_valid_d  = id_valid_q;
        buf_d       = buf_q;
        lost_addr_d = lost_addr_q;
        bubble      = 1'b0;
        case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                if (imemReady) begin
                    if (!pcWrite) begin
                        buf_d   = imemData;
                        state_d = HELD;
                    end else if (pcSrc) begin
                        bubble = 1'b1;
                        pc_d   = redirectTarget;
                    end else begin
                        id_pc_d    = pc_plus4;
                        id_ins_d   = imemData;
                        id_valid_d = 1'b1;
                        pc_d       = pc_plus4;
                    end
                end else if (pcWrite) begin
                    bubble = 1'b1;
                    if (pcSrc) begin
                        // Response for this address may still arrive; remember it so it can be dropped.
                        lost_addr_d = pc_q;
                        pc_d        = redirectTarget;
                        state_d     = DISCARD;
                    end
                end
            end
            HELD: begin
                if (pcWrite) begin
                    state_d = FETCH;
                    if (pcSrc) begin
                        bubble = 1'b1;
                        pc_d   = redirectTarget;
                    end else begin
                        id_pc_d    = pc_plus4;
                        id_ins_d   = buf_q;
                        id_valid_d = 1'b1;
                        pc_d       = pc_plus4;
                    end
                end
            end
            DISCARD: begin
                if (pcWrite) begin
                    bubble = 1'b1;
                    if (pcSrc) pc_d = redirectTarget;
                end
                if (imemReady) state_d = FETCH;
            end
            default: state_d = BOOT;
        endcase
        if (bubble || flush) begin
            id_pc_d    = 32'h0;
            id_ins_d   = 32'h0;
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            id_pc_q     <= 32'h0;
            id_ins_q    <= 32'h0;
            id_valid_q  <= 1'b0;
            buf_q       <= 32'h0;
            lost_addr_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            id_pc_q     <= id_pc_d;
            id_ins_q    <= id_ins_d;
            id_valid_q  <= id_valid_d;
            buf_q       <= buf_d;
            lost_addr_q <= lost_addr_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage against a behavioural fetch model
// Two instances share stimulus: default RESET_PC and RESET_PC=32'hFFFFFFFC for the wrap case.
module tb_fetch_stage;

    logic        Clock = 1'b0;
    logic        Reset, pcWrite, flush, pcSrc, imemReady;
    logic [31:0] redirectTarget;
    logic [31:0] dsalt;

    logic        req0, req1, valid0, valid1;
    logic [31:0] addr0, addr1, pcif0, pcif1, pcid0, pcid1, ins0, ins1;
    logic [31:0] data0, data1;

    int tests  = 0;
    int failed = 0;

    always #5 Clock = ~Clock;

    // Memory answers with its own address, optionally scrambled by a per-cycle salt.
    assign data0 = addr0 ^ dsalt;
    assign data1 = addr1 ^ dsalt;

    fetch_stage dut0 (
        .Clock(Clock), .Reset(Reset), .pcWrite(pcWrite), .flush(flush), .pcSrc(pcSrc),
        .redirectTarget(redirectTarget), .imemReq(req0), .imemAddr(addr0),
        .imemReady(imemReady), .imemData(data0), .pcIF(pcif0), .pcID(pcid0),
        .instructionID(ins0), .validID(valid0)
    );

    fetch_stage #(.RESET_PC(32'hFFFFFFFC)) dut1 (
        .Clock(Clock), .Reset(Reset), .pcWrite(pcWrite), .flush(flush), .pcSrc(pcSrc),
        .redirectTarget(redirectTarget), .imemReq(req1), .imemAddr(addr1),
        .imemReady(imemReady), .imemData(data1), .pcIF(pcif1), .pcID(pcid1),
        .instructionID(ins1), .validID(valid1)
    );

    // Model: booting / waiting-with-held-word / draining-abandoned-request, plus IF/ID contents.
    logic [31:0] m_rpc  [2] = '{32'h0, 32'hFFFFFFFC};
    logic [31:0] m_pc   [2] = '{32'h0, 32'h0};
    logic [31:0] m_idpc [2] = '{32'h0, 32'h0};
    logic [31:0] m_ins  [2] = '{32'h0, 32'h0};
    logic [31:0] m_buf  [2] = '{32'h0, 32'h0};
    logic [31:0] m_daddr[2] = '{32'h0, 32'h0};
    bit          m_v    [2] = '{0, 0};
    bit          m_boot [2] = '{1, 1};
    bit          m_held [2] = '{0, 0};
    bit          m_disc [2] = '{0, 0};

    function automatic logic [129:0] exp_vec(int k);
        logic        r;
        logic [31:0] a;
        r = !m_boot[k] && !m_held[k];
        a = r ? (m_disc[k] ? m_daddr[k] : m_pc[k]) : 32'h0;
        return {r, a, m_pc[k], m_idpc[k], m_ins[k], m_v[k]};
    endfunction

    function automatic logic [129:0] dut_vec(int k);
        if (k == 0) return {req0, req0 ? addr0 : 32'h0, pcif0, pcid0, ins0, valid0};
        return {req1, req1 ? addr1 : 32'h0, pcif1, pcid1, ins1, valid1};
    endfunction

    task automatic model_step(int k);
        logic [31:0] a, d;
        a = m_disc[k] ? m_daddr[k] : m_pc[k];
        d = a ^ dsalt;
        if (!Reset) begin
            m_boot[k] = 1; m_held[k] = 0; m_disc[k] = 0; m_pc[k] = m_rpc[k];
            m_idpc[k] = 0; m_ins[k] = 0; m_v[k] = 0;
            return;
        end
        if (m_boot[k]) begin
            m_boot[k] = 0;
        end else if (m_held[k]) begin
            if (pcWrite) begin
                m_held[k] = 0;
                if (pcSrc) begin
                    m_idpc[k] = 0; m_ins[k] = 0; m_v[k] = 0; m_pc[k] = redirectTarget;
                end else begin
                    m_pc[k] = m_pc[k] + 4; m_idpc[k] = m_pc[k]; m_ins[k] = m_buf[k]; m_v[k] = 1;
                end
            end
        end else if (m_disc[k]) begin
            if (pcWrite) begin m_idpc[k] = 0; m_ins[k] = 0; m_v[k] = 0; end
            if (pcWrite && pcSrc) m_pc[k] = redirectTarget;
            if (imemReady) m_disc[k] = 0;
        end else if (imemReady && !pcWrite) begin
            m_held[k] = 1; m_buf[k] = d;
        end else if (imemReady && !pcSrc) begin
            m_pc[k] = m_pc[k] + 4; m_idpc[k] = m_pc[k]; m_ins[k] = d; m_v[k] = 1;
        end else if (pcWrite) begin
            m_idpc[k] = 0; m_ins[k] = 0; m_v[k] = 0;
            if (pcSrc) begin
                if (!imemReady) begin m_disc[k] = 1; m_daddr[k] = m_pc[k]; end
                m_pc[k] = redirectTarget;
            end
        end
        if (flush) begin m_idpc[k] = 0; m_ins[k] = 0; m_v[k] = 0; end
    endtask

    task automatic cycle(input logic rst, pw, fl, ps, rdy, input logic [31:0] tgt);
        Reset = rst; pcWrite = pw; flush = fl; pcSrc = ps; imemReady = rdy; redirectTarget = tgt;
        @(posedge Clock);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic test_reset;
        dsalt = 0;
        cycle(0, 1, 0, 0, 0, 0);
        tests++;
        if (pcif0 !== 32'h0 || req0 !== 1'b0 || valid0 !== 1'b0 || ins0 !== 32'h0 || pcid0 !== 32'h0) begin
            failed++;
            $display("FAIL reset_state: pcIF=%h req=%b valid=%b ins=%h pcID=%h, want 0/0/0/0/0",
                     pcif0, req0, valid0, ins0, pcid0);
        end
        tests++;
        if (pcif1 !== 32'hFFFFFFFC) begin
            failed++; $display("FAIL reset_pc_param: pcIF=%h want fffffffc", pcif1);
        end
    endtask

    task automatic test_sequential;
        dsalt = 0;
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (req0 !== 1'b1 || addr0 !== 32'(4 * i)) begin
                failed++; $display("FAIL seq_addr%0d: req=%b addr=%h want 1/%h", i, req0, addr0, 4 * i);
            end
            cycle(1, 1, 0, 0, 1, 0);
        end
        tests++;
        if (pcid0 !== 32'd12 || ins0 !== 32'd8 || valid0 !== 1'b1) begin
            failed++; $display("FAIL seq_ifid: pcID=%h ins=%h valid=%b want c/8/1", pcid0, ins0, valid0);
        end
    endtask

    task automatic test_stall;
        logic [64:0] held;
        held = {pcid0, ins0, valid0};
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 0, 1, 0);
            tests++;
            if (req0 !== 1'b0 || {pcid0, ins0, valid0} !== held || pcif0 !== 32'd12) begin
                failed++;
                $display("FAIL stall_hold%0d: req=%b ifid=%h pcIF=%h want 0/%h/c", i, req0,
                         {pcid0, ins0, valid0}, pcif0, held);
            end
        end
        cycle(1, 1, 0, 0, 1, 0);
        tests++;
        if (pcid0 !== 32'd16 || ins0 !== 32'd12 || valid0 !== 1'b1 || pcif0 !== 32'd16) begin
            failed++;
            $display("FAIL stall_release: pcID=%h ins=%h valid=%b pcIF=%h want 10/c/1/10",
                     pcid0, ins0, valid0, pcif0);
        end
    endtask

    task automatic test_redirect;
        dsalt = 0;
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 1, 0);
        cycle(1, 1, 0, 1, 0, 32'h40);
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (req0 !== 1'b1 || addr0 !== 32'h10 || pcif0 !== 32'h40 || valid0 !== 1'b0) begin
                failed++;
                $display("FAIL redirect_wait%0d: req=%b addr=%h pcIF=%h valid=%b want 1/10/40/0",
                         i, req0, addr0, pcif0, valid0);
            end
            cycle(1, 1, 0, 0, i == 1, 0);
        end
        tests++;
        if (req0 !== 1'b1 || addr0 !== 32'h40 || valid0 !== 1'b0) begin
            failed++; $display("FAIL redirect_drop: req=%b addr=%h valid=%b want 1/40/0", req0, addr0, valid0);
        end
        cycle(1, 1, 0, 0, 1, 0);
        tests++;
        if (ins0 !== 32'h40 || pcid0 !== 32'h44 || valid0 !== 1'b1) begin
            failed++; $display("FAIL redirect_fetch: ins=%h pcID=%h valid=%b want 40/44/1", ins0, pcid0, valid0);
        end
    endtask

    task automatic test_flush;
        logic [31:0] pc;
        pc = pcif0;
        cycle(1, 0, 1, 1, 0, 32'h100);
        tests++;
        if (valid0 !== 1'b0 || ins0 !== 32'h0 || pcid0 !== 32'h0 || pcif0 !== pc) begin
            failed++;
            $display("FAIL flush_stalled: valid=%b ins=%h pcID=%h pcIF=%h want 0/0/0/%h",
                     valid0, ins0, pcid0, pcif0, pc);
        end
    endtask

    task automatic test_wrap;
        dsalt = 0;
        cycle(0, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 1, 0);
        tests++;
        if (pcif1 !== 32'h0 || pcid1 !== 32'h0 || ins1 !== 32'hFFFFFFFC || valid1 !== 1'b1) begin
            failed++;
            $display("FAIL wrap: pcIF=%h pcID=%h ins=%h valid=%b want 0/0/fffffffc/1", pcif1, pcid1, ins1, valid1);
        end
    endtask

    task automatic test_reset_discard;
        cycle(1, 1, 0, 1, 0, 32'h80);
        cycle(0, 1, 0, 0, 1, 0);
        tests++;
        if (pcif0 !== 32'h0 || req0 !== 1'b0 || valid0 !== 1'b0) begin
            failed++; $display("FAIL reset_discard: pcIF=%h req=%b valid=%b want 0/0/0", pcif0, req0, valid0);
        end
        cycle(1, 1, 0, 0, 1, 0);
        tests++;
        if (req0 !== 1'b1 || addr0 !== 32'h0 || valid0 !== 1'b0) begin
            failed++; $display("FAIL reset_discard_boot: req=%b addr=%h valid=%b want 1/0/0", req0, addr0, valid0);
        end
    endtask

    task automatic test_random;
        logic [31:0] t;
        dsalt = 0;
        cycle(0, 1, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            t     = $urandom;
            dsalt = $urandom;
            cycle($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, {t[31:2], 2'b00});
            for (int k = 0; k < 2; k++) begin
                tests++;
                if (dut_vec(k) !== exp_vec(k)) begin
                    failed++;
                    $display("FAIL random%0d_inst%0d: got %h want %h", n, k, dut_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    initial begin
        Reset = 0; pcWrite = 0; flush = 0; pcSrc = 0; imemReady = 0; redirectTarget = 0; dsalt = 0;
        test_reset;
        test_sequential;
        test_stall;
        test_redirect;
        test_flush;
        test_wrap;
        test_reset_discard;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
